// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter block.
// Provides the FSM state type, the grant codes reported on o_grant, the
// requester bit positions used by the pick logic, and bus widths.
package vram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Bit positions of each requester in the request vector handed to the picker
  localparam int REQ_V   = 0;
  localparam int REQ_C   = 1;
  localparam int REQ_D   = 2;
  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Encoding is visible on o_grant for debug/performance counters
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_V    = 2'd1,
    GRANT_C    = 2'd2,
    GRANT_D    = 2'd3
  } grant_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of every handshake/bus signal around the VRAM arbiter.
// Signal names are written from the arbiter's point of view (i_ = into the
// arbiter, o_ = out of it).
//   V port : i_v_request, i_v_address -> o_v_rdata, o_v_ready
//   C port : i_c_request, i_c_rw, i_c_address, i_c_wdata -> o_c_rdata, o_c_ready
//   D port : i_d_request, i_d_rw, i_d_address, i_d_wdata -> o_d_rdata, o_d_ready
//   Memory : o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata <- i_mem_rdata, i_mem_ready
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (requesters plus memory controller)
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  logic              i_v_request;
  logic [ADDR_W-1:0] i_v_address;
  logic [DATA_W-1:0] o_v_rdata;
  logic              o_v_ready;

  logic              i_c_request;
  logic              i_c_rw;
  logic [ADDR_W-1:0] i_c_address;
  logic [DATA_W-1:0] i_c_wdata;
  logic [DATA_W-1:0] o_c_rdata;
  logic              o_c_ready;

  logic              i_d_request;
  logic              i_d_rw;
  logic [ADDR_W-1:0] i_d_address;
  logic [DATA_W-1:0] i_d_wdata;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_d_ready;

  logic              o_mem_request;
  logic              o_mem_rw;
  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  modport slave (
    input  i_v_request, i_v_address,
    output o_v_rdata, o_v_ready,
    input  i_c_request, i_c_rw, i_c_address, i_c_wdata,
    output o_c_rdata, o_c_ready,
    input  i_d_request, i_d_rw, i_d_address, i_d_wdata,
    output o_d_rdata, o_d_ready,
    output o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata,
    input  i_mem_rdata, i_mem_ready
  );

  modport master (
    output i_v_request, i_v_address,
    input  o_v_rdata, o_v_ready,
    output i_c_request, i_c_rw, i_c_address, i_c_wdata,
    input  o_c_rdata, o_c_ready,
    output i_d_request, i_d_rw, i_d_address, i_d_wdata,
    input  o_d_rdata, o_d_ready,
    input  o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata,
    output i_mem_rdata, i_mem_ready
  );

endinterface

// File: rtl/vram_arb_pick.sv
// Combinational winner selection for the VRAM arbiter.
// Ports:
//   requests    - request vector indexed by REQ_V/REQ_C/REQ_D
//   rr_prefer_d - round-robin pointer, 0 favours C, 1 favours D
//   burst_limit - video has used up its consecutive-grant allowance
//   grant       - winning requester, GRANT_NONE when nobody asks
module vram_arb_pick
  import vram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] requests,
  input  logic               rr_prefer_d,
  input  logic               burst_limit,
  output grant_t             grant
);

  logic cd_pending;

  assign cd_pending = requests[REQ_C] | requests[REQ_D];

  // Video wins unless it has exhausted its burst and someone else is waiting;
  // the round-robin pointer only matters when C and D both ask.
  always_comb begin
    grant = GRANT_NONE;
    if (requests[REQ_V] && !(burst_limit && cd_pending)) begin
      grant = GRANT_V;
    end else if (requests[REQ_C] && requests[REQ_D]) begin
      grant = rr_prefer_d ? GRANT_D : GRANT_C;
    end else if (requests[REQ_C]) begin
      grant = GRANT_C;
    end else if (requests[REQ_D]) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM port between video scanout (V), the CPU write-FIFO drain (C)
// and a blitter/DMA engine (D). One transaction is in flight at a time and
// every port uses a four-phase request/ready handshake.
// Ports:
//   i_clock, i_reset - clock and synchronous active-high reset
//   bus              - all requester and memory-side signals (slave modport)
//   o_grant          - current owner: 0 none, 1 V, 2 C, 3 D
// Parameter MAX_VIDEO_BURST (1..255) caps back-to-back video grants while C
// or D is waiting.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int MAX_VIDEO_BURST = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  vram_arbiter_if.slave bus,
  output grant_t        o_grant
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_VIDEO_BURST);

  state_t              state;
  logic                rr_prefer_d;
  logic [7:0]          burst_cnt;

  logic                mem_request_q;
  logic                mem_rw_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   v_rdata_q;
  logic [DATA_W-1:0]   c_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                v_ready_q;
  logic                c_ready_q;
  logic                d_ready_q;

  logic [NUM_REQ-1:0]  requests;
  logic                cd_pending;
  logic                burst_limit;
  logic                owner_request;
  grant_t              pick;

  assign requests[REQ_V] = bus.i_v_request;
  assign requests[REQ_C] = bus.i_c_request;
  assign requests[REQ_D] = bus.i_d_request;
  assign cd_pending      = bus.i_c_request | bus.i_d_request;
  assign burst_limit     = (burst_cnt == BURST_MAX);

  vram_arb_pick u_pick (
    .requests    (requests),
    .rr_prefer_d (rr_prefer_d),
    .burst_limit (burst_limit),
    .grant       (pick)
  );

  // Request line of whoever currently owns the memory; ACK waits on it
  always_comb begin
    owner_request = 1'b0;
    case (o_grant)
      GRANT_V: owner_request = bus.i_v_request;
      GRANT_C: owner_request = bus.i_c_request;
      GRANT_D: owner_request = bus.i_d_request;
      default: owner_request = 1'b0;
    endcase
  end

  // Single FSM: IDLE picks and latches a winner, BUSY waits for memory, ACK
  // holds the owner's ready until its request falls. A reset in BUSY simply
  // drops everything, so the abandoned access never produces a ready.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_grant       <= GRANT_NONE;
      rr_prefer_d   <= 1'b0;
      burst_cnt     <= '0;
      mem_request_q <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      v_rdata_q     <= '0;
      c_rdata_q     <= '0;
      d_rdata_q     <= '0;
      v_ready_q     <= 1'b0;
      c_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != GRANT_NONE) begin
            o_grant       <= pick;
            mem_request_q <= 1'b1;
            state         <= BUSY;
          end
          case (pick)
            GRANT_V: begin
              mem_address_q <= bus.i_v_address;
              mem_rw_q      <= 1'b0;
              mem_wdata_q   <= '0;
              // Only count video grants that actually delay someone else
              if (cd_pending) begin
                burst_cnt <= burst_limit ? burst_cnt : burst_cnt + 8'd1;
              end else begin
                burst_cnt <= '0;
              end
            end
            GRANT_C: begin
              mem_address_q <= bus.i_c_address;
              mem_rw_q      <= bus.i_c_rw;
              mem_wdata_q   <= bus.i_c_wdata;
              rr_prefer_d   <= 1'b1;
              burst_cnt     <= '0;
            end
            GRANT_D: begin
              mem_address_q <= bus.i_d_address;
              mem_rw_q      <= bus.i_d_rw;
              mem_wdata_q   <= bus.i_d_wdata;
              rr_prefer_d   <= 1'b0;
              burst_cnt     <= '0;
            end
            default: ;
          endcase
        end

        BUSY: begin
          if (bus.i_mem_ready) begin
            mem_request_q <= 1'b0;
            state         <= ACK;
            case (o_grant)
              GRANT_V: begin
                v_rdata_q <= bus.i_mem_rdata;
                v_ready_q <= 1'b1;
              end
              GRANT_C: begin
                if (!mem_rw_q) c_rdata_q <= bus.i_mem_rdata;
                c_ready_q <= 1'b1;
              end
              GRANT_D: begin
                if (!mem_rw_q) d_rdata_q <= bus.i_mem_rdata;
                d_ready_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ACK: begin
          if (!owner_request) begin
            v_ready_q <= 1'b0;
            c_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            o_grant   <= GRANT_NONE;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_request = mem_request_q;
  assign bus.o_mem_rw      = mem_rw_q;
  assign bus.o_mem_address = mem_address_q;
  assign bus.o_mem_wdata   = mem_wdata_q;
  assign bus.o_v_rdata     = v_rdata_q;
  assign bus.o_c_rdata     = c_rdata_q;
  assign bus.o_d_rdata     = d_rdata_q;
  assign bus.o_v_ready     = v_ready_q;
  assign bus.o_c_ready     = c_ready_q;
  assign bus.o_d_ready     = d_ready_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a table of per-cycle input/expected
// records followed by hand-written sequences for burst limiting, reset in
// BUSY and a request dropped mid-transaction.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam logic [31:0] VA = 32'h0000_0200;
  localparam logic [31:0] CA = 32'h0000_0100;
  localparam logic [31:0] CW = 32'hDEAD_BEEF;
  localparam logic [31:0] DA = 32'h0000_0300;
  localparam logic [31:0] DW = 32'hCAFE_F00D;
  localparam logic [31:0] VR = 32'h1234_5678;
  localparam logic [31:0] C1 = 32'hC000_0001;
  localparam logic [31:0] D2 = 32'hD000_0002;
  localparam logic [31:0] C3 = 32'hC000_0003;
  localparam logic [31:0] D4 = 32'hD000_0004;

  typedef struct {
    logic        rst, v, c, c_rw, d, d_rw, mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mreq, e_rw;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_grant;
    logic        e_vr, e_cr, e_dr;
    logic [31:0] e_vrd, e_crd, e_drd;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  grant_t grant;
  int     checks = 0;
  int     failures = 0;
  vec_t   vecs[$];

  vram_arbiter_if bus();

  vram_arbiter #(.MAX_VIDEO_BURST(8)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_grant (grant)
  );

  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges despite its own bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t vv);
    rst             = vv.rst;
    bus.i_v_request = vv.v;
    bus.i_v_address = VA;
    bus.i_c_request = vv.c;
    bus.i_c_rw      = vv.c_rw;
    bus.i_c_address = CA;
    bus.i_c_wdata   = CW;
    bus.i_d_request = vv.d;
    bus.i_d_rw      = vv.d_rw;
    bus.i_d_address = DA;
    bus.i_d_wdata   = DW;
    bus.i_mem_ready = vv.mem_ready;
    bus.i_mem_rdata = vv.mem_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkRow(input int i, input vec_t vv);
    checkOutput($sformatf("row%0d mem_request", i), 32'(bus.o_mem_request), 32'(vv.e_mreq));
    checkOutput($sformatf("row%0d grant", i), 32'(grant), 32'(vv.e_grant));
    checkOutput($sformatf("row%0d v_ready", i), 32'(bus.o_v_ready), 32'(vv.e_vr));
    checkOutput($sformatf("row%0d c_ready", i), 32'(bus.o_c_ready), 32'(vv.e_cr));
    checkOutput($sformatf("row%0d d_ready", i), 32'(bus.o_d_ready), 32'(vv.e_dr));
    checkOutput($sformatf("row%0d v_rdata", i), bus.o_v_rdata, vv.e_vrd);
    checkOutput($sformatf("row%0d c_rdata", i), bus.o_c_rdata, vv.e_crd);
    checkOutput($sformatf("row%0d d_rdata", i), bus.o_d_rdata, vv.e_drd);
    if (vv.e_mreq) begin
      checkOutput($sformatf("row%0d mem_rw", i), 32'(bus.o_mem_rw), 32'(vv.e_rw));
      checkOutput($sformatf("row%0d mem_address", i), bus.o_mem_address, vv.e_addr);
      checkOutput($sformatf("row%0d mem_wdata", i), bus.o_mem_wdata, vv.e_wdata);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.i_v_request = 1'b0;
    bus.i_c_request = 1'b0;
    bus.i_d_request = 1'b0;
    bus.i_mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits (bounded) for a memory request, answers it after one cycle, checks
  // the owner's ready, then drops the owner's request and lets ACK release.
  task automatic serveOne(input string tag, input logic [31:0] rdata, output logic [1:0] g);
    int n = 0;
    while (!bus.o_mem_request && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, " mem_request_seen"}, 32'(bus.o_mem_request), 32'd1);
    g = grant;
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = rdata;
    @(posedge clk);
    #1;
    bus.i_mem_ready = 1'b0;
    case (g)
      2'd1:    checkOutput({tag, " v_ready"}, 32'(bus.o_v_ready), 32'd1);
      2'd2:    checkOutput({tag, " c_ready"}, 32'(bus.o_c_ready), 32'd1);
      default: checkOutput({tag, " d_ready"}, 32'(bus.o_d_ready), 32'd1);
    endcase
    if (g == 2'd1) bus.i_v_request = 1'b0;
    if (g == 2'd2) bus.i_c_request = 1'b0;
    if (g == 2'd3) bus.i_d_request = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] burst_exp[10];

    rst = 1'b1;
    bus.i_v_request = 1'b0; bus.i_v_address = VA;
    bus.i_c_request = 1'b0; bus.i_c_rw = 1'b0; bus.i_c_address = CA; bus.i_c_wdata = CW;
    bus.i_d_request = 1'b0; bus.i_d_rw = 1'b0; bus.i_d_address = DA; bus.i_d_wdata = DW;
    bus.i_mem_ready = 1'b0; bus.i_mem_rdata = '0;

    // rst v c crw d drw mrdy mrdata | mreq rw addr wdata grant vr cr dr vrd crd drd
    // Single C write, memory answers on the third BUSY cycle
    vecs.push_back('{1,0,0,0,0,0,0,0,            0,0,0,0,   0,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            1,1,CA,CW, 2,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            1,1,CA,CW, 2,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            1,1,CA,CW, 2,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,1,0,0,1,32'hBAD0BAD0, 0,0,0,0,   2,0,1,0, 0,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            0,0,0,0,   2,0,1,0, 0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,            0,0,0,0,   0,0,0,0, 0,0,0});
    // V read and C write together: V first, then C
    vecs.push_back('{0,1,1,1,0,0,0,0,            1,0,VA,0,  1,0,0,0, 0,0,0});
    vecs.push_back('{0,1,1,1,0,0,1,VR,           0,0,0,0,   1,1,0,0, VR,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            0,0,0,0,   0,0,0,0, VR,0,0});
    vecs.push_back('{0,0,1,1,0,0,0,0,            1,1,CA,CW, 2,0,0,0, VR,0,0});
    vecs.push_back('{0,0,1,1,0,0,1,32'h55555555, 0,0,0,0,   2,0,1,0, VR,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,            0,0,0,0,   0,0,0,0, VR,0,0});
    // C and D reads held together: C, D, C, D
    vecs.push_back('{1,0,0,0,0,0,0,0,            0,0,0,0,   0,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,0,1,0,0,0,            1,0,CA,CW, 2,0,0,0, 0,0,0});
    vecs.push_back('{0,0,1,0,1,0,1,C1,           0,0,0,0,   2,0,1,0, 0,C1,0});
    vecs.push_back('{0,0,0,0,1,0,0,0,            0,0,0,0,   0,0,0,0, 0,C1,0});
    vecs.push_back('{0,0,1,0,1,0,0,0,            1,0,DA,DW, 3,0,0,0, 0,C1,0});
    vecs.push_back('{0,0,1,0,1,0,1,D2,           0,0,0,0,   3,0,0,1, 0,C1,D2});
    vecs.push_back('{0,0,1,0,0,0,0,0,            0,0,0,0,   0,0,0,0, 0,C1,D2});
    vecs.push_back('{0,0,1,0,1,0,0,0,            1,0,CA,CW, 2,0,0,0, 0,C1,D2});
    vecs.push_back('{0,0,1,0,1,0,1,C3,           0,0,0,0,   2,0,1,0, 0,C3,D2});
    vecs.push_back('{0,0,0,0,1,0,0,0,            0,0,0,0,   0,0,0,0, 0,C3,D2});
    vecs.push_back('{0,0,1,0,1,0,0,0,            1,0,DA,DW, 3,0,0,0, 0,C3,D2});
    vecs.push_back('{0,0,1,0,1,0,1,D4,           0,0,0,0,   3,0,0,1, 0,C3,D4});
    vecs.push_back('{0,0,0,0,0,0,0,0,            0,0,0,0,   0,0,0,0, 0,C3,D4});
    // Stray memory ready while IDLE must be ignored
    vecs.push_back('{0,0,0,0,0,0,1,32'hFFFFFFFF, 0,0,0,0,   0,0,0,0, 0,C3,D4});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkRow(i, vecs[i]);
    end

    // Burst limit: V and a C write held continuously -> 8 V, 1 C, then V
    for (int k = 0; k < 10; k++) burst_exp[k] = (k == 8) ? 2'd2 : 2'd1;
    doReset();
    bus.i_c_rw = 1'b1;
    bus.i_v_request = 1'b1;
    bus.i_c_request = 1'b1;
    for (int k = 0; k < 10; k++) begin
      serveOne($sformatf("burst%0d", k), 32'h0000_1000 + 32'(k), g);
      checkOutput($sformatf("burst%0d grant", k), 32'(g), 32'(burst_exp[k]));
      bus.i_v_request = 1'b1;
      bus.i_c_request = 1'b1;
    end

    // Reset while BUSY abandons the access without a ready
    doReset();
    bus.i_c_request = 1'b1;
    bus.i_c_rw = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstbusy granted", 32'(bus.o_mem_request), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstbusy mem_request", 32'(bus.o_mem_request), 32'd0);
    checkOutput("rstbusy readys", {29'd0, bus.o_v_ready, bus.o_c_ready, bus.o_d_ready}, 32'd0);
    checkOutput("rstbusy grant", 32'(grant), 32'd0);
    rst = 1'b0;
    bus.i_c_request = 1'b0;
    bus.i_mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rstbusy late_ready%0d", k),
                  {28'd0, bus.o_mem_request, bus.o_v_ready, bus.o_c_ready, bus.o_d_ready}, 32'd0);
    end
    bus.i_mem_ready = 1'b0;

    // D drops its request during BUSY: access completes, one-cycle ready
    doReset();
    bus.i_d_request = 1'b1;
    bus.i_d_rw = 1'b0;
    @(posedge clk); #1;
    checkOutput("ddrop grant", 32'(grant), 32'd3);
    bus.i_d_request = 1'b0;
    @(posedge clk); #1;
    checkOutput("ddrop still_busy", 32'(bus.o_mem_request), 32'd1);
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.i_mem_ready = 1'b0;
    checkOutput("ddrop d_ready_high", 32'(bus.o_d_ready), 32'd1);
    checkOutput("ddrop mem_request_low", 32'(bus.o_mem_request), 32'd0);
    checkOutput("ddrop d_rdata", bus.o_d_rdata, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    checkOutput("ddrop d_ready_low", 32'(bus.o_d_ready), 32'd0);
    checkOutput("ddrop grant_cleared", 32'(grant), 32'd0);
    bus.i_c_request = 1'b1;
    bus.i_c_rw = 1'b0;
    @(posedge clk); #1;
    checkOutput("ddrop idle_regrant", 32'(grant), 32'd2);
    checkOutput("ddrop idle_mem_request", 32'(bus.o_mem_request), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
